// File: rtl/mul_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
package mul_pkg;

    localparam int MUL_W     = 64;
    localparam int MUL_CNT_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/bit_Adder.sv
// 64-bit ripple-carry adder: sum/cout = a + b + cin.
module bit_Adder
    import mul_pkg::*;
(
    input  logic [MUL_W-1:0] a,
    input  logic [MUL_W-1:0] b,
    input  logic             cin,
    output logic [MUL_W-1:0] sum,
    output logic             cout
);

    logic carry;

    // Ripple the carry bit by bit from LSB to MSB.
    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < MUL_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/shift_add_mul64.sv
// Sequential 64x64 unsigned radix-2 shift-and-add multiplier, 128-bit product.
// Optional feature macro: MUL_EARLY_TERM_EN -- stop as soon as the remaining
// multiplier bits are all zero and realign the product.
module shift_add_mul64
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);

    mul_state_e           state, state_nxt;
    logic [WIDTH-1:0]     a_q, p_q, m_q;
    logic [MUL_CNT_W-1:0] cnt_q, cnt_nxt;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;
    logic [WIDTH-1:0]     s, p_nxt, m_nxt;
    logic                 c;
    logic                 finish;
    logic [2*WIDTH-1:0]   prod_nxt;
`ifdef MUL_EARLY_TERM_EN
    logic [WIDTH-1:0]     rem_mask;
`endif

    bit_Adder u_adder (
        .a    (p_q),
        .b    (a_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // One iteration: conditional add, then shift {c,S,M} right by one.
    always_comb begin
        c        = m_q[0] ? add_cout : 1'b0;
        s        = m_q[0] ? add_sum  : p_q;
        p_nxt    = {c, s[WIDTH-1:1]};
        m_nxt    = {s[0], m_q[WIDTH-1:1]};
        cnt_nxt  = cnt_q + 1'b1;
`ifdef MUL_EARLY_TERM_EN
        // After cnt_nxt shifts, the unconsumed multiplier bits sit in
        // m_nxt[WIDTH-1-cnt_nxt:0]; at cnt_nxt=WIDTH the mask is empty.
        rem_mask = {WIDTH{1'b1}} >> cnt_nxt;
        finish   = (m_nxt & rem_mask) == '0;
        prod_nxt = {p_nxt, m_nxt} >> (WIDTH - int'(cnt_nxt));
`else
        finish   = (cnt_nxt == MUL_CNT_W'(WIDTH));
        prod_nxt = {p_nxt, m_nxt};
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> DONE when finished, DONE lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)  state_nxt = RUN;
            RUN:     if (finish) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ready = (state == IDLE);
    assign done  = (state == DONE);

    // Operand latch, iteration registers and product output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            p_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            prod_hi <= '0;
            prod_lo <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_q   <= a_in;
                    p_q   <= '0;
                    m_q   <= b_in;
                    cnt_q <= '0;
                end
                RUN: begin
                    p_q   <= p_nxt;
                    m_q   <= m_nxt;
                    cnt_q <= cnt_nxt;
                    if (finish) begin
                        prod_hi <= prod_nxt[2*WIDTH-1:WIDTH];
                        prod_lo <= prod_nxt[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
